seq_cla_adder: RTL

SEQ_CLA_ADDER -- requirements
Module: seq_cla_adder

---
 rtl/seq_cla_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_cla_adder.sv
// Multi-cycle adder: one 4-bit carry-lookahead slice per clock, LSB slice first.
// Define SEQ_CLA_SUB_EN to add the 'sub' port (A - B computed as A + ~B + 1).
module seq_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SEQ_CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int SLICES = WIDTH / 4;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [3:0]       sl_a, sl_b, sl_s;
  logic             sl_c3, sl_c4;
  logic             accept;

  // Returns {carry out, carry into bit 3, 4-bit sum}; bit-3 carry feeds overflow.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

`ifdef SEQ_CLA_SUB_EN
  assign b_in = sub ? ~B : B;
  assign c_in = sub | Cin;
`else
  assign b_in = B;
  assign c_in = Cin;
`endif

  assign accept = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    sl_a    = a_r[3:0];
    sl_b    = b_r[3:0];
    for (int k = 0; k < SLICES; k++) begin
      if (idx == IDX_W'(k)) begin
        sl_a = a_r[4*k +: 4];
        sl_b = b_r[4*k +: 4];
      end
    end
    {sl_c4, sl_c3, sl_s} = cla4(sl_a, sl_b, carry);
    acc_nxt = acc;
    for (int k = 0; k < SLICES; k++) begin
      if (idx == IDX_W'(k)) acc_nxt[4*k +: 4] = sl_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // S/Cout/ovf load only on the final slice, so partial sums never reach S.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_r   <= A;
      b_r   <= b_in;
      carry <= c_in;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      carry <= sl_c4;
      idx   <= idx + IDX_W'(1);
      if (idx == LAST) begin
        S    <= acc_nxt;
        Cout <= sl_c4;
        ovf  <= sl_c4 ^ sl_c3;
      end
    end
  end

endmodule
